// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..max_val with load, wrap or saturate
// at the boundaries, a terminal-count flag and a wrap pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam bit SAT = (SAT_MODE == CNT_SAT);

  logic [WIDTH-1:0] count_nxt;
  logic             at_top;
  logic             at_bot;

  assign at_top = (count >= max_val);
  assign at_bot = (count == '0);
  assign tc     = en & ~load & ((up & at_top) | (~up & at_bot));

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = (load_val < max_val) ? load_val : max_val;
    end else if (en) begin
      if (up) begin
        // count above a lowered max_val is treated as the top
        if (at_top)
          count_nxt = SAT ? max_val : '0;
        else
          count_nxt = count + WIDTH'(1);
      end else begin
        if (at_bot)
          count_nxt = SAT ? '0 : max_val;
        else if (count > max_val)
          count_nxt = max_val;
        else
          count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= tc;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized scoreboard bench for updown_mod_counter, WIDTH=4,
// running a wrapping and a saturating instance side by side.
module tb_updown_mod_counter;
  import counter_pkg::*;

  localparam int W = 4;

  typedef struct {
    int cw;
    bit ww;
    bit tw;
    int cs;
    bit ws;
    bit ts;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = '0;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, wrap_w, wrap_s;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;

  // model state: counts are plain integers
  int  m_cw, m_cs;
  bit  m_ww, m_ws;
  bit  known = 1'b0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .SAT_MODE(CNT_WRAP)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_w), .tc(tc_w), .wrap(wrap_w)
  );

  updown_mod_counter #(.WIDTH(W), .SAT_MODE(CNT_SAT)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_s), .tc(tc_s), .wrap(wrap_s)
  );

  function automatic bit ref_tc(int c, bit e, bit u, bit l, int m);
    return e && !l && ((u && c >= m) || (!u && c == 0));
  endfunction

  function automatic int ref_next(int c, bit sat, bit e, bit u,
                                  bit l, int lv, int m);
    if (l) return (lv < m) ? lv : m;
    if (!e) return c;
    if (u) begin
      if (c >= m) return sat ? m : 0;
      return c + 1;
    end
    if (c == 0) return sat ? 0 : m;
    if (c > m) return m;
    return c - 1;
  endfunction

  task automatic step(bit r, bit e, bit u, bit l, int lv, int m);
    exp_t x;
    bit   tw, ts;
    @(posedge clk);
    #1;
    rst = r; en = e; up = u; load = l;
    load_val = W'(lv); max_val = W'(m);
    tw = ref_tc(m_cw, e, u, l, m);
    ts = ref_tc(m_cs, e, u, l, m);
    if (known) begin
      x.cw = m_cw; x.ww = m_ww; x.tw = tw;
      x.cs = m_cs; x.ws = m_ws; x.ts = ts;
      q.push_back(x);
    end
    if (r) begin
      m_cw = 0; m_cs = 0; m_ww = 0; m_ws = 0;
      known = 1'b1;
    end else if (known) begin
      m_cw = ref_next(m_cw, 1'b0, e, u, l, lv, m);
      m_cs = ref_next(m_cs, 1'b1, e, u, l, lv, m);
      m_ww = tw;
      m_ws = ts;
    end
  endtask

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("count_wrap", int'(count_w), x.cw);
      chk("wrap_wrap", int'(wrap_w), int'(x.ww));
      chk("tc_wrap", int'(tc_w), int'(x.tw));
      chk("count_sat", int'(count_s), x.cs);
      chk("wrap_sat", int'(wrap_s), int'(x.ws));
      chk("tc_sat", int'(tc_s), int'(x.ts));
    end
  end

  initial begin
    int m;
    int lv;
    int budget;
    // reset with a competing load
    step(1, 0, 1, 1, 9, 9);
    step(1, 0, 1, 1, 9, 9);
    // wrap up over 0..9
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 9);
    // load 2 then count down into the bottom
    step(0, 0, 0, 1, 2, 5);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 5);
    // load clamp beats enable
    step(0, 1, 1, 1, 13, 6);
    step(0, 0, 1, 0, 0, 6);
    // run-time max shrink, up then down
    step(0, 0, 1, 1, 12, 15);
    step(0, 1, 1, 0, 0, 7);
    step(0, 0, 1, 1, 12, 15);
    step(0, 1, 0, 0, 0, 7);
    // full range and hold
    step(0, 0, 1, 1, 14, 15);
    step(0, 1, 1, 0, 0, 15);
    step(0, 1, 1, 0, 0, 15);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 15);
    // zero modulus, then reset on a terminal-count cycle
    for (int i = 0; i < 3; i++) step(0, 1, i[0], 0, 0, 0);
    step(0, 0, 1, 1, 4, 4);
    step(0, 1, 1, 0, 0, 4);
    step(1, 1, 1, 0, 0, 4);
    step(0, 1, 0, 0, 0, 4);
    // direction flips every cycle
    for (int i = 0; i < 8; i++) step(0, 1, i[0], 0, 0, 3);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: m = 0;
        1: m = 15;
        default: m = $urandom_range(0, 15);
      endcase
      lv = $urandom_range(0, 15);
      step(($urandom_range(0, 40) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), lv, m);
    end
    step(0, 0, 0, 0, 0, 15);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #10;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, load and modulus width in bits; legal range 2..32.
REQ-002 Parameter SAT_MODE, default 0: 0 = wrap at boundaries, 1 = saturate (hold) at boundaries.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port en  input  1: count enable; one step per enabled cycle.
REQ-006 Port up  input  1: direction; 1 = increment, 0 = decrement.
REQ-007 Port load  input  1: synchronous load request.
REQ-008 Port load_val  input  WIDTH: value loaded when load=1.
REQ-009 Port max_val  input  WIDTH: inclusive upper bound of count range 0..max_val; sampled every cycle.
REQ-010 Port count  output  WIDTH: registered counter value.
REQ-011 Port tc  output  1: combinational terminal-count flag.
REQ-012 Port wrap  output  1: registered one-cycle pulse after a boundary wrap or saturation hit.

Function
REQ-013 Per-edge priority SHALL be rst > load > en; with en=0 and load=0, count SHALL hold.
REQ-014 Load: count SHALL become min(load_val, max_val) on the next edge, regardless of en or up.
REQ-015 Up step, count < max_val: count SHALL become count+1.
REQ-016 Up step, count == max_val: count SHALL become 0 (SAT_MODE=0) or hold max_val (SAT_MODE=1).
REQ-017 Down step, count > 0: count SHALL become count-1; if count > max_val, count SHALL become max_val.
REQ-018 Down step, count == 0: count SHALL become max_val (SAT_MODE=0) or hold 0 (SAT_MODE=1).
REQ-019 Up step with count > max_val (max_val lowered at run time): count SHALL become 0 (SAT_MODE=0) or max_val (SAT_MODE=1).
REQ-020 max_val == 0: every enabled step SHALL leave count at 0 and assert the boundary condition.
REQ-021 All arithmetic SHALL be WIDTH bits; no intermediate carry SHALL reach count; max_val = 2^WIDTH-1 SHALL give natural binary wrap.
REQ-022 tc SHALL equal en & ~load & ((up & count>=max_val) | (~up & count==0)), same cycle, no register.
REQ-023 wrap SHALL be 1 for exactly the cycle after any edge where tc was 1, and 0 otherwise.
REQ-024 Direction change SHALL take effect on the same edge it is sampled; there SHALL be no turnaround cycle.

Reset
REQ-025 On any edge with rst=1, count SHALL be 0 and wrap SHALL be 0 from the following cycle, overriding load and en.
REQ-026 Reset mid-count SHALL discard any in-flight wrap pulse; tc SHALL follow REQ-022 with count=0.
REQ-027 No output SHALL be X after the first edge with rst=1.

Structure
REQ-028 Package counter_pkg SHALL hold the mode constants CNT_WRAP=0 and CNT_SAT=1; SAT_MODE SHALL be set with them.
REQ-029 Implementation SHALL be one module: one registered always block for count and wrap, plus combinational next-state and tc logic; no sub-module.

Verification (WIDTH=4)
REQ-030 Reset: rst=1 for 2 cycles with load=1, load_val=9 -> count=0, wrap=0.
REQ-031 Wrap up: SAT_MODE=0, max_val=9, up=1, en=1 from count=0 for 12 cycles -> 0..9,0,1; tc high at 9; wrap high one cycle after.
REQ-032 Down, saturate: SAT_MODE=1, max_val=5, load 2, up=0, en=1 for 4 cycles -> 1,0,0,0; tc high while count=0.
REQ-033 Load clamp and priority: max_val=6, load=1, load_val=13, en=1 -> count=6, tc=0 that cycle.
REQ-034 Run-time max shrink: count=12, max_val changed 15->7, up=1 -> count=0 (wrap) or 7 (sat); up=0 from 12 -> 7.
REQ-035 Full range and hold: max_val=15, up=1 from 14 -> 15,0; en=0 for 5 cycles -> count constant, tc=0.
